// File: rtl/mul_pkg.sv
// Shared widths, settle-count limits and state encoding for the multiply issue controller.
package mul_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned DEST_W     = 3;
    localparam int unsigned SETTLE_MIN = 1;
    localparam int unsigned SETTLE_MAX = 15;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

endpackage

// File: rtl/mul_issue_ctrl.sv
// Issue/capture controller in front of the combinational multiplier: registers operands,
// waits SETTLE_CYCLES edges, captures the product and holds it for writeback. Option: MUL_SKID_EN.
module mul_issue_ctrl #(
    parameter int unsigned DATA_W        = mul_pkg::DATA_W,
    parameter int unsigned DEST_W        = mul_pkg::DEST_W,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [DATA_W-1:0] REQ_OP1,
    input  logic [DATA_W-1:0] REQ_OP2,
    input  logic [DEST_W-1:0] REQ_DEST,
    output logic [DATA_W-1:0] MUL_IN1,
    output logic [DATA_W-1:0] MUL_IN2,
    input  logic [DATA_W-1:0] MUL_OUT,
    output logic              RES_VALID,
    input  logic              RES_READY,
    output logic [DATA_W-1:0] RES_DATA,
    output logic [DEST_W-1:0] RES_DEST,
    output logic              BUSY
);
    import mul_pkg::*;

    if (SETTLE_CYCLES < SETTLE_MIN || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
        $error("mul_issue_ctrl: SETTLE_CYCLES must be in 1..15");
    end

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [DEST_W-1:0]   dest, dest_nx;
    logic [DATA_W-1:0]   in1_nx, in2_nx, data_nx;
    logic [DEST_W-1:0]   rdest_nx;
    logic                valid_nx;
    logic                accept;

`ifdef MUL_SKID_EN
    // A retiring result frees the operand registers on the same edge.
    assign REQ_READY = RESET && ((state == IDLE) || (state == HOLD && RES_READY));
`else
    assign REQ_READY = RESET && (state == IDLE);
`endif

    assign accept = REQ_VALID && REQ_READY;
    assign BUSY   = (state != IDLE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dest_nx  = dest;
        in1_nx   = MUL_IN1;
        in2_nx   = MUL_IN2;
        data_nx  = RES_DATA;
        rdest_nx = RES_DEST;
        valid_nx = RES_VALID;

        case (state)
            IDLE: begin
                if (accept) state_nx = SETTLE;
            end
            SETTLE: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    data_nx  = MUL_OUT;
                    rdest_nx = dest;
                    valid_nx = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (RES_READY) begin
                    valid_nx = 1'b0;
                    state_nx = accept ? SETTLE : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // accept only ever fires in IDLE or HOLD, so this never overlaps the SETTLE countdown
        if (accept) begin
            in1_nx  = REQ_OP1;
            in2_nx  = REQ_OP2;
            dest_nx = REQ_DEST;
            cnt_nx  = CNT_W'(SETTLE_CYCLES);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            dest      <= '0;
            MUL_IN1   <= '0;
            MUL_IN2   <= '0;
            RES_DATA  <= '0;
            RES_DEST  <= '0;
            RES_VALID <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            dest      <= dest_nx;
            MUL_IN1   <= in1_nx;
            MUL_IN2   <= in2_nx;
            RES_DATA  <= data_nx;
            RES_DEST  <= rdest_nx;
            RES_VALID <= valid_nx;
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: two instances (SETTLE_CYCLES 1 and 3) against a transaction-timing model,
// plus directed literal checks. Define MUL_SKID_EN to exercise the skid option.
`timescale 1ns/1ps
module tb_mul_issue_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #4 clk = ~clk;

    logic [1:0]      req_valid = '0;
    logic [1:0]      res_ready = '1;
    logic [1:0][7:0] op1 = '0;
    logic [1:0][7:0] op2 = '0;
    logic [1:0][2:0] dest = '0;
    wire  [1:0]      req_ready, res_valid, busy;
    wire  [1:0][7:0] mul_in1, mul_in2, res_data;
    wire  [1:0][2:0] res_dest;
    logic [7:0]      mul_out0 = '0, mul_out1 = '0;
    logic [15:0]     prod0, prod1;

    int tests = 0;
    int fails = 0;

    mul_issue_ctrl #(.DATA_W(8), .DEST_W(3), .SETTLE_CYCLES(1)) dut1 (
        .CLK(clk), .RESET(rst_n),
        .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
        .REQ_OP1(op1[0]), .REQ_OP2(op2[0]), .REQ_DEST(dest[0]),
        .MUL_IN1(mul_in1[0]), .MUL_IN2(mul_in2[0]), .MUL_OUT(mul_out0),
        .RES_VALID(res_valid[0]), .RES_READY(res_ready[0]),
        .RES_DATA(res_data[0]), .RES_DEST(res_dest[0]), .BUSY(busy[0])
    );

    mul_issue_ctrl #(.DATA_W(8), .DEST_W(3), .SETTLE_CYCLES(3)) dut3 (
        .CLK(clk), .RESET(rst_n),
        .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
        .REQ_OP1(op1[1]), .REQ_OP2(op2[1]), .REQ_DEST(dest[1]),
        .MUL_IN1(mul_in1[1]), .MUL_IN2(mul_in2[1]), .MUL_OUT(mul_out1),
        .RES_VALID(res_valid[1]), .RES_READY(res_ready[1]),
        .RES_DATA(res_data[1]), .RES_DEST(res_dest[1]), .BUSY(busy[1])
    );

    // Combinational multiplier stand-ins with propagation delay
    always @(mul_in1[0], mul_in2[0]) begin
        #3;
        prod0 = {8'h00, mul_in1[0]} * {8'h00, mul_in2[0]};
        mul_out0 = prod0[7:0];
    end
    always @(mul_in1[1], mul_in2[1]) begin
        #3;
        prod1 = {8'h00, mul_in1[1]} * {8'h00, mul_in2[1]};
        mul_out1 = prod1[7:0];
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model: result due a fixed number of edges after accept
`ifdef MUL_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    int         edge_n = 0;
    int         m_due[2] = '{-1, -1};
    bit         m_valid[2];
    logic [7:0] m_data[2], m_in1[2], m_in2[2];
    logic [2:0] m_dest[2], m_pdest[2];

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] low_prod(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = {8'h00, a} * {8'h00, b};
        return p[7:0];
    endfunction

    function automatic bit m_ready(input int k);
        return rst_n && ((!m_valid[k] && m_due[k] < 0) || (SKID && m_valid[k] && res_ready[k]));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_due[k] = -1; m_valid[k] = 0; m_data[k] = '0; m_dest[k] = '0;
                m_in1[k] = '0; m_in2[k] = '0; m_pdest[k] = '0;
            end
        end else begin
            edge_n++;
            for (int k = 0; k < 2; k++) begin
                bit acc;
                acc = req_valid[k] && m_ready(k);
                if (m_due[k] == edge_n) begin
                    m_valid[k] = 1;
                    m_data[k]  = low_prod(m_in1[k], m_in2[k]);
                    m_dest[k]  = m_pdest[k];
                    m_due[k]   = -1;
                end else if (m_valid[k] && res_ready[k]) begin
                    m_valid[k] = 0;
                end
                if (acc) begin
                    m_in1[k]   = op1[k];
                    m_in2[k]   = op2[k];
                    m_pdest[k] = dest[k];
                    m_due[k]   = edge_n + settle_of(k);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("req_ready", k, 32'(req_ready[k]), 32'(m_ready(k)));
            chk("res_valid", k, 32'(res_valid[k]), 32'(m_valid[k]));
            chk("busy",      k, 32'(busy[k]),      32'(m_valid[k] || m_due[k] >= 0));
            chk("res_data",  k, 32'(res_data[k]),  32'(m_data[k]));
            chk("res_dest",  k, 32'(res_dest[k]),  32'(m_dest[k]));
            chk("mul_in1",   k, 32'(mul_in1[k]),   32'(m_in1[k]));
            chk("mul_in2",   k, 32'(mul_in2[k]),   32'(m_in2[k]));
        end
    end

    // ---------------- directed helpers
    task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
        bit done;
        done = 0;
        req_valid[k] = 1'b1; op1[k] = a; op2[k] = b; dest[k] = d;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (req_ready[k]) begin
                @(posedge clk);
                #2;
                req_valid[k] = 1'b0;
                done = 1;
            end
        end
        if (!done) chk("issue_timeout", k, 0, 1);
    endtask

    task automatic wait_res(input int k, input logic [7:0] d, input logic [2:0] ds, input string name);
        bit done;
        done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (res_valid[k]) begin
                chk({name, "_data"}, k, 32'(res_data[k]), 32'(d));
                chk({name, "_dest"}, k, 32'(res_dest[k]), 32'(ds));
                done = 1;
            end
        end
        if (!done) chk({name, "_timeout"}, k, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #22;
        chk("rst_req_ready", 0, 32'(req_ready[0]), 0);
        chk("rst_res_valid", 0, 32'(res_valid[0]), 0);
        chk("rst_busy",      0, 32'(busy[0]), 0);
        chk("rst_mul_in1",   0, 32'(mul_in1[0]), 0);
        chk("rst_res_data",  0, 32'(res_data[0]), 0);
        #7 rst_n = 1'b1;
        @(posedge clk); #2;

        // 5 x 3 with one settle edge
        issue(0, 8'd5, 8'd3, 3'd2);
        @(negedge clk);
        chk("t1_settle_valid", 0, 32'(res_valid[0]), 0);
        chk("t1_settle_busy",  0, 32'(busy[0]), 1);
        chk("t1_in1",          0, 32'(mul_in1[0]), 5);
        chk("t1_in2",          0, 32'(mul_in2[0]), 3);
        @(negedge clk);
        chk("t1_valid", 0, 32'(res_valid[0]), 1);
        chk("t1_data",  0, 32'(res_data[0]), 32'h0F);
        chk("t1_dest",  0, 32'(res_dest[0]), 2);
        chk("t1_busy",  0, 32'(busy[0]), 1);

        // truncation
        @(posedge clk); #2;
        issue(0, 8'hFF, 8'hFF, 3'd7);
        wait_res(0, 8'h01, 3'd7, "t2");

        // backpressure with a second request pending
        @(posedge clk); #2;
        res_ready[0] = 1'b0;
        issue(0, 8'd9, 8'd10, 3'd5);
        req_valid[0] = 1'b1; op1[0] = 8'd3; op2[0] = 8'd3; dest[0] = 3'd1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 0, 32'(res_valid[0]), 1);
            chk("t3_hold_data",  0, 32'(res_data[0]), 32'h5A);
            chk("t3_hold_ready", 0, 32'(req_ready[0]), 0);
        end
        @(posedge clk); #2;
        res_ready[0] = 1'b1;
        @(negedge clk);
        chk("t3_ready_on_retire", 0, 32'(req_ready[0]), 32'(SKID));
        if (!SKID) begin
            @(negedge clk);
            chk("t3_ready_after", 0, 32'(req_ready[0]), 1);
            chk("t3_valid_after", 0, 32'(res_valid[0]), 0);
        end
        @(posedge clk); #2;
        req_valid[0] = 1'b0;
        wait_res(0, 8'h09, 3'd1, "t3b");

        // reset while settling discards the request
        @(posedge clk); #2;
        issue(0, 8'd7, 8'd9, 3'd3);
        #3 rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", 0, 32'(res_valid[0]), 0);
        chk("t4_rst_busy",  0, 32'(busy[0]), 0);
        chk("t4_rst_in1",   0, 32'(mul_in1[0]), 0);
        chk("t4_rst_data",  0, 32'(res_data[0]), 0);
        chk("t4_rst_ready", 0, 32'(req_ready[0]), 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_no_result", 0, 32'(res_valid[0]), 0);
        end
        @(posedge clk); #2;
        issue(0, 8'd2, 8'd4, 3'd0);
        wait_res(0, 8'h08, 3'd0, "t4b");

        // three settle edges
        @(posedge clk); #2;
        issue(1, 8'd11, 8'd13, 3'd6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_settle_valid", 1, 32'(res_valid[1]), 0);
            chk("t5_in1", 1, 32'(mul_in1[1]), 11);
            chk("t5_in2", 1, 32'(mul_in2[1]), 13);
        end
        @(negedge clk);
        chk("t5_valid", 1, 32'(res_valid[1]), 1);
        chk("t5_data",  1, 32'(res_data[1]), 32'h8F);
        chk("t5_dest",  1, 32'(res_dest[1]), 6);

        // random traffic on both instances, model-checked every cycle
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            if (i == 200) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            for (int k = 0; k < 2; k++) begin
                req_valid[k] = ($urandom_range(0, 2) != 0);
                res_ready[k] = ($urandom_range(0, 3) != 0);
                op1[k]  = 8'($urandom);
                op2[k]  = 8'($urandom);
                dest[k] = 3'($urandom);
            end
        end
        @(posedge clk); #2;
        req_valid = '0;
        res_ready = '1;
        repeat (10) @(posedge clk);
        #2;

`ifdef MUL_SKID_EN
        begin
            logic [7:0] ea[3], eb[3], ex[3], got_d[3];
            int got_c[3];
            int got, idx, cyc;
            bit acc_pend;
            ea = '{8'd2, 8'd4, 8'd6}; eb = '{8'd3, 8'd5, 8'd7}; ex = '{8'h06, 8'h14, 8'h2A};
            got = 0; idx = 0; cyc = 0;
            op1[0] = ea[0]; op2[0] = eb[0]; dest[0] = 3'd1;
            req_valid[0] = 1'b1; res_ready[0] = 1'b1;
            while (cyc < 30 && got < 3) begin
                @(negedge clk);
                cyc++;
                if (res_valid[0]) begin
                    got_d[got] = res_data[0];
                    got_c[got] = cyc;
                    got++;
                end
                acc_pend = req_ready[0] && req_valid[0];
                @(posedge clk); #2;
                if (acc_pend) begin
                    idx++;
                    if (idx < 3) begin
                        op1[0] = ea[idx]; op2[0] = eb[idx];
                    end else begin
                        req_valid[0] = 1'b0;
                    end
                end
            end
            chk("t6_count", 0, 32'(got), 3);
            for (int i = 0; i < got && i < 3; i++) begin
                chk("t6_data", i, 32'(got_d[i]), 32'(ex[i]));
                if (i > 0) chk("t6_spacing", i, 32'(got_c[i] - got_c[i-1]), 2);
            end
            req_valid[0] = 1'b0;
            repeat (4) @(posedge clk);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
